des_block_packer: RTL

//   Upstream feeder for the DES wrapper: packs an 8-bit byte stream into 64-bit DES blocks.

---
 rtl/des_block_packer.sv | 112 +++++++++++
 1 files changed

// File: rtl/des_block_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : des_block_packer                                                |
// | Packs an 8-bit byte stream MSB-first into 64-bit DES blocks and queues     |
// | them in a DEPTH-slot FIFO popped by the DES core's next_data pulse.        |
// | Option   : define DES_PACKER_PAD_EN to enable zero-padded flush of a       |
// |            partial block.                                                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module des_block_packer #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic          flush,
    output logic [63:0]   data_out,
    output logic          ready,
    input  logic          next_data,
    output logic [AW:0]   blk_count,
    output logic          underrun
);

    logic [2:0]  byte_cnt;
    logic [2:0]  cnt_next;
    logic [63:0] assembler;
    logic [63:0] assembled;
    logic [63:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        flush_pend;
    logic        flush_set;
    logic        full;
    logic        empty;
    logic        accept;
    logic        byte_commit;
    logic        pad_commit;
    logic        commit;
    logic        pop;

    // Pointers carry one extra MSB so a full FIFO reads as DEPTH rather than 0.
    assign blk_count   = wr_ptr - rd_ptr;
    assign full        = blk_count[AW];
    assign empty       = (blk_count == '0);
    assign ready       = !empty;
    assign data_out    = empty ? 64'h0 : mem[rd_ptr[AW-1:0]];

    // Only the block-completing byte needs a free slot; earlier bytes sit in the assembler.
    assign byte_ready  = !((byte_cnt == 3'd7) && full) && !flush_pend;
    assign accept      = byte_valid && byte_ready;
    assign cnt_next    = accept ? byte_cnt + 3'd1 : byte_cnt;
    assign assembled   = accept ? (assembler | ({byte_in, 56'h0} >> {byte_cnt, 3'b000}))
                                : assembler;
    assign byte_commit = accept && (byte_cnt == 3'd7);
    assign pad_commit  = flush_pend && !full;
    assign commit      = byte_commit || pad_commit;
    assign pop         = next_data && !empty;

`ifdef DES_PACKER_PAD_EN
    assign flush_set   = flush && !flush_pend && (cnt_next != 3'd0);
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_set    = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_cnt   <= 3'd0;
            assembler  <= 64'h0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            flush_pend <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (pad_commit) begin
                byte_cnt   <= 3'd0;
                assembler  <= 64'h0;
                flush_pend <= 1'b0;
            end else begin
                if (accept) begin
                    byte_cnt  <= cnt_next;
                    assembler <= byte_commit ? 64'h0 : assembled;
                end
                if (flush_set) begin
                    flush_pend <= 1'b1;
                end
            end
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (next_data && empty) begin
                underrun <= 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only visible through the non-empty head.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr[AW-1:0]] <= assembled;
        end
    end

endmodule
`default_nettype wire
